// File: rtl/din_cond_pkg.sv
// Shared definitions for the input-conditioning blocks: debouncer FSM encoding and defaults.
package din_cond_pkg;

  typedef enum logic [1:0] {
    IDLE_LO = 2'd0,
    WAIT_HI = 2'd1,
    IDLE_HI = 2'd2,
    WAIT_LO = 2'd3
  } din_state_e;

  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 1000;

endpackage : din_cond_pkg

// File: rtl/sync_ff_chain.sv
// Multi-flop synchroniser bringing an asynchronous bit into the clk domain.
module sync_ff_chain #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_q;
  logic [STAGES-1:0] chain_d;

  always_comb begin
    chain_d = {chain_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chain_q <= '0;
    end else begin
      chain_q <= chain_d;
    end
  end

  assign q = chain_q[STAGES-1];

endmodule : sync_ff_chain

// File: rtl/din_debouncer.sv
// Synchronise and debounce a raw input; emit a clean level, edge strobes and a busy flag.
module din_debouncer
  import din_cond_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din_raw,
  output logic dout,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  logic din_s;

  din_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dout_q, dout_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             busy_q, busy_d;

  sync_ff_chain #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (din_raw),
    .q     (din_s)
  );

  // A candidate level must be seen DEBOUNCE_CYCLES+1 consecutive cycles before it is accepted.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    dout_d  = dout_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      IDLE_LO: begin
        if (din_s) begin
          state_d = WAIT_HI;
          cnt_d   = CNT_W'(1);
        end
      end
      WAIT_HI: begin
        if (!din_s) begin
          state_d = IDLE_LO;
        end else if (cnt_q == CNT_MAX) begin
          state_d = IDLE_HI;
          dout_d  = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      IDLE_HI: begin
        if (!din_s) begin
          state_d = WAIT_LO;
          cnt_d   = CNT_W'(1);
        end
      end
      WAIT_LO: begin
        if (din_s) begin
          state_d = IDLE_HI;
        end else if (cnt_q == CNT_MAX) begin
          state_d = IDLE_LO;
          dout_d  = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE_LO;
      end
    endcase
    busy_d = (state_d == WAIT_HI) || (state_d == WAIT_LO);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE_LO;
      cnt_q   <= '0;
      dout_q  <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      busy_q  <= busy_d;
    end
  end

  assign dout = dout_q;
  assign rise = rise_q;
  assign fall = fall_q;
  assign busy = busy_q;

endmodule : din_debouncer

// File: tb/tb_din_debouncer.sv
// Directed and randomized bench for din_debouncer, checked against a run-length reference model.
module tb_din_debouncer;
  import din_cond_pkg::*;

  localparam int unsigned SYNC = 2;
  localparam int unsigned DEB  = 4;
  localparam int unsigned LAT  = SYNC + DEB + 1;

  logic clk = 1'b0;
  logic rst_n;
  logic din_raw;
  logic dout, rise, fall, busy;

  int checks = 0;
  int errors = 0;

  // Reference model: delay line for the synchroniser, run length of disagreement for the debouncer.
  logic q_sync[$];
  int   m_run;
  logic m_dout, m_rise, m_fall, m_busy;
  logic prev_strobe;

  din_debouncer #(
    .SYNC_STAGES     (SYNC),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .din_raw (din_raw),
    .dout    (dout),
    .rise    (rise),
    .fall    (fall),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q_sync.delete();
    for (int i = 0; i < int'(SYNC); i++) q_sync.push_back(1'b0);
    m_run  = 0;
    m_dout = 1'b0;
    m_rise = 1'b0;
    m_fall = 1'b0;
    m_busy = 1'b0;
  endtask

  task automatic model_edge(input logic raw, input logic rst);
    logic s;
    if (!rst) begin
      model_reset();
    end else begin
      s = q_sync.pop_front();
      q_sync.push_back(raw);
      m_rise = 1'b0;
      m_fall = 1'b0;
      if (s != m_dout) m_run++;
      else m_run = 0;
      if (m_run == int'(DEB) + 1) begin
        m_dout = s;
        m_rise = s;
        m_fall = !s;
        m_run  = 0;
      end
      m_busy = (m_run != 0);
    end
  endtask

  // One clock: drive at negedge, update model at posedge, compare 1 time unit later.
  task automatic step(input logic raw, input logic rst);
    @(negedge clk);
    din_raw = raw;
    rst_n   = rst;
    @(posedge clk);
    model_edge(raw, rst);
    #1;
    chk("dout", int'(dout), int'(m_dout));
    chk("rise", int'(rise), int'(m_rise));
    chk("fall", int'(fall), int'(m_fall));
    chk("busy", int'(busy), int'(m_busy));
    chk("rise_and_fall_exclusive", int'(rise && fall), 0);
    chk("strobe_not_back_to_back", int'(prev_strobe && (rise || fall)), 0);
    prev_strobe = rise || fall;
  endtask

  initial begin
    int n, busy_cnt, rise_cnt, fall_cnt, rise_edge, fall_edge;
    logic bounce[6];
    logic v;
    int   len;

    prev_strobe = 1'b0;
    din_raw     = 1'b1;
    rst_n       = 1'b0;
    model_reset();

    // 1: reset held with din_raw high, then qualified normally after release
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0);
      chk("t1_reset_dout", int'(dout), 0);
      chk("t1_reset_busy", int'(busy), 0);
    end
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      step(1'b1, 1'b1);
      if (rise && n == 0) n = i;
    end
    chk("t1_rise_edge", n, int'(LAT));
    chk("t1_dout_held", int'(dout), 1);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1);
    chk("t1_back_low", int'(dout), 0);

    // 2: clean 0->1 step held 20 cycles
    busy_cnt = 0; rise_cnt = 0; fall_cnt = 0; rise_edge = 0;
    for (int i = 1; i <= 20; i++) begin
      step(1'b1, 1'b1);
      if (busy) busy_cnt++;
      if (rise) begin rise_cnt++; if (rise_edge == 0) rise_edge = i; end
      if (fall) fall_cnt++;
    end
    chk("t2_busy_cycles", busy_cnt, int'(DEB));
    chk("t2_rise_edge", rise_edge, int'(LAT));
    chk("t2_rise_count", rise_cnt, 1);
    chk("t2_fall_count", fall_cnt, 0);
    chk("t2_dout", int'(dout), 1);

    // 5: falling step with dout high
    fall_cnt = 0; fall_edge = 0; rise_cnt = 0;
    for (int i = 1; i <= 20; i++) begin
      step(1'b0, 1'b1);
      if (fall) begin fall_cnt++; if (fall_edge == 0) fall_edge = i; end
      if (rise) rise_cnt++;
    end
    chk("t5_fall_edge", fall_edge, int'(LAT));
    chk("t5_fall_count", fall_cnt, 1);
    chk("t5_rise_count", rise_cnt, 0);
    chk("t5_dout", int'(dout), 0);

    // 3: glitch shorter than the qualification window
    rise_cnt = 0;
    for (int i = 0; i < 3; i++) begin step(1'b1, 1'b1); if (rise) rise_cnt++; end
    for (int i = 0; i < 10; i++) begin step(1'b0, 1'b1); if (rise) rise_cnt++; end
    chk("t3_rise_count", rise_cnt, 0);
    chk("t3_dout", int'(dout), 0);
    chk("t3_busy_idle", int'(busy), 0);

    // 4: bounce train then stable high; rise counted from the final 0->1
    bounce = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    rise_cnt = 0;
    for (int i = 0; i < 5; i++) begin step(bounce[i], 1'b1); if (rise) rise_cnt++; end
    rise_edge = 0;
    for (int i = 1; i <= 15; i++) begin
      step(1'b1, 1'b1);
      if (rise) begin rise_cnt++; if (rise_edge == 0) rise_edge = i; end
    end
    chk("t4_rise_edge", rise_edge, int'(LAT));
    chk("t4_rise_count", rise_cnt, 1);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1);
    chk("t4_back_low", int'(dout), 0);

    // 6: reset asserted mid-qualification
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1);
    chk("t6_cnt_before", int'(dut.cnt_q), 2);
    chk("t6_busy_before", int'(busy), 1);
    step(1'b1, 1'b0);
    chk("t6_state", int'(dut.state_q), int'(IDLE_LO));
    chk("t6_cnt", int'(dut.cnt_q), 0);
    chk("t6_busy", int'(busy), 0);
    chk("t6_dout", int'(dout), 0);
    chk("t6_no_strobe", int'(rise || fall), 0);

    // Randomized runs of varying length, with occasional reset pulses
    for (int r = 0; r < 60; r++) begin
      v   = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 9));
      for (int i = 0; i < len; i++) step(v, ($urandom_range(0, 40) != 0));
    end
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_din_debouncer
